serial_add_sub: RTL

Parametrised multi-cycle adder/subtractor for the ALU arithmetic path. It generalises the 1-bit full adder (`i_a`, `i_b`, `i_c` in; `o_o`, `o_c` out) to WIDTH-bit operands. Operands are processed DIGIT bits per clock with a registered carry chain, behind a start/busy/done handshake. It adds subtract mode plus signed-overflow and zero flags, and sits beside the combinational ALU ops for wide operations where a full-width ripple chain would not close timing.

---
 rtl/serial_add_sub.sv | 110 +++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: WIDTH-bit adder/subtractor that processes DIGIT bits per clock through a registered carry chain.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic [WIDTH-1:0] o_o,
    output logic             o_c,
    output logic             o_v,
    output logic             o_z,
    output logic             o_busy,
    output logic             o_done
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, o_q, o_d;
    logic             c_q, c_d, v_q, v_d, z_q, z_d, done_q, done_d;
    logic [DIGIT:0]   dsum;
    logic             msb_cin;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        dsum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // carry into the digit MSB recovered from its sum bit and operand bits
        msb_cin  = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        res_next = (res_q >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        o_d      = o_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (i_start) begin
                state_d = RUN;
                cnt_d   = '0;
                a_d     = i_a;
                b_d     = i_sub ? ~i_b : i_b;
                carry_d = i_c;
            end
        end else begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = dsum[DIGIT];
            res_d   = res_next;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(N - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                o_d     = res_next;
                c_d     = dsum[DIGIT];
                v_d     = msb_cin ^ dsum[DIGIT];
                z_d     = (res_next == '0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            o_q     <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            o_q     <= o_d;
            c_q     <= c_d;
            v_q     <= v_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign o_o    = o_q;
    assign o_c    = c_q;
    assign o_v    = v_q;
    assign o_z    = z_q;
    assign o_busy = (state_q == RUN);
    assign o_done = done_q;
endmodule
